gpio_bank: RTL and testbench

GPIO_BANK -- requirements
Module: gpio_bank

---
 rtl/gpio_pkg.sv | 24 ++
 rtl/gpio_sync.sv | 40 ++++
 rtl/gpio_bank.sv | 166 ++++++++++++++++
 tb/tb_gpio_bank.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg -- shared types and limits for the GPIO bank.
//
// Contents:
//   wr_op_t          : output-register write operation (WRITE/SET/CLEAR/TOGGLE)
//   WIDTH_MIN/MAX    : legal range of the pin-count parameter
//   SYNC_MIN/MAX     : legal range of the input synchroniser depth
//   WARM_W           : width of the post-reset warm-up counter, sized so that
//                      SYNC_MAX+1 fits
package gpio_pkg;

   typedef enum logic [1:0] {
      OP_WRITE  = 2'b00,
      OP_SET    = 2'b01,
      OP_CLEAR  = 2'b10,
      OP_TOGGLE = 2'b11
   } wr_op_t;

   localparam int WIDTH_MIN = 1;
   localparam int WIDTH_MAX = 32;
   localparam int SYNC_MIN  = 2;
   localparam int SYNC_MAX  = 4;
   localparam int WARM_W    = 3;

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync -- WIDTH-bit wide, STAGES-deep flop chain used to bring the
// asynchronous pad values into the clk_i domain.
//
// Ports:
//   clk_i : clock, all flops on the rising edge
//   rst_i : synchronous active-high reset, clears every stage
//   d_i   : raw (asynchronous) input bits
//   q_o   : output of the last stage
module gpio_sync
   import gpio_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = SYNC_MIN
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] chain_q [STAGES];

   // Shift the raw input down the chain one stage per clock; the first
   // stage may go metastable, later stages give it time to settle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < STAGES; s++) begin
            chain_q[s] <= '0;
         end
      end else begin
         chain_q[0] <= d_i;
         for (int s = 1; s < STAGES; s++) begin
            chain_q[s] <= chain_q[s-1];
         end
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank -- bank of WIDTH bidirectional GPIO pins with an output register
// supporting write/set/clear/toggle, synchronised pad readback and optional
// edge-detect interrupts.
//
// Build option: define GPIO_IRQ_EN to include edge detection, sticky status,
// the post-reset warm-up counter and the registered interrupt. Without it
// irq_status_o and irq_o are tied low and the irq_* inputs are ignored.
//
// Ports:
//   clk_i          : clock
//   rst_i          : synchronous active-high reset
//   dir_i          : per-pin direction, 1 = output, 0 = input (registered)
//   wr_en_i        : output-register write strobe
//   wr_op_i        : 00 WRITE, 01 SET, 10 CLEAR, 11 TOGGLE
//   wr_data_i      : write data or bit mask
//   out_o          : output register
//   data_o         : synchronised pad value (all pins)
//   inout_io       : pads, driven from out_o where the pin is an output
//   irq_rise_en_i  : per-pin rising-edge enable
//   irq_fall_en_i  : per-pin falling-edge enable
//   irq_mask_i     : per-pin interrupt enable
//   irq_clr_i      : write-1-to-clear for status bits
//   irq_status_o   : sticky edge status
//   irq_o          : interrupt request
module gpio_bank
   import gpio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] dir_i,
   input  logic             wr_en_i,
   input  logic [1:0]       wr_op_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic [WIDTH-1:0] out_o,
   output logic [WIDTH-1:0] data_o,
   inout  wire  [WIDTH-1:0] inout_io,
   input  logic [WIDTH-1:0] irq_rise_en_i,
   input  logic [WIDTH-1:0] irq_fall_en_i,
   input  logic [WIDTH-1:0] irq_mask_i,
   input  logic [WIDTH-1:0] irq_clr_i,
   output logic [WIDTH-1:0] irq_status_o,
   output logic             irq_o
);

   logic [WIDTH-1:0] dir_q;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_next;

   // Direction is registered so pads switch cleanly on a clock edge; reset
   // leaves every pad floating.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dir_q <= '0;
      end else begin
         dir_q <= dir_i;
      end
   end

   // Next value of the output register for the requested operation; the
   // register simply holds when no write is strobed.
   always_comb begin
      out_next = out_q;
      if (wr_en_i) begin
         case (wr_op_t'(wr_op_i))
            OP_WRITE:  out_next = wr_data_i;
            OP_SET:    out_next = out_q | wr_data_i;
            OP_CLEAR:  out_next = out_q & ~wr_data_i;
            OP_TOGGLE: out_next = out_q ^ wr_data_i;
            default:   out_next = out_q;
         endcase
      end
   end

   // Output register; reset wins over any write in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q <= '0;
      end else begin
         out_q <= out_next;
      end
   end

   assign out_o = out_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pad
      assign inout_io[i] = dir_q[i] ? out_q[i] : 1'bz;
   end

   // Every pad is synchronised, outputs included, so software can read back
   // what is really on the pin.
   gpio_sync #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (inout_io),
      .q_o   (data_o)
   );

`ifdef GPIO_IRQ_EN

   localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(SYNC_STAGES + 1);

   logic [WIDTH-1:0]  prev_q;
   logic [WIDTH-1:0]  status_q;
   logic [WARM_W-1:0] warm_q;
   logic              irq_q;
   logic [WIDTH-1:0]  rise;
   logic [WIDTH-1:0]  fall;
   logic [WIDTH-1:0]  set_vec;

   // Edge detection against the previous synchronised sample. Only input
   // pins may raise status, and nothing is reported until the warm-up has
   // flushed the reset zeros out of the sync chain and prev_q.
   always_comb begin
      rise    = data_o & ~prev_q;
      fall    = ~data_o & prev_q;
      set_vec = ((rise & irq_rise_en_i) | (fall & irq_fall_en_i))
                & ~dir_q & {WIDTH{warm_q == '0}};
   end

   // Previous-sample register and the warm-up down-counter, which is loaded
   // on reset and stops at zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q <= '0;
         warm_q <= WARM_LOAD;
      end else begin
         prev_q <= data_o;
         if (warm_q != '0) begin
            warm_q <= warm_q - 1'b1;
         end
      end
   end

   // Sticky status: clear first, then OR in new edges so a set coincident
   // with a clear leaves the bit set. Masked bits are kept so they show up
   // once unmasked.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         status_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         status_q <= (status_q & ~irq_clr_i) | set_vec;
         irq_q    <= |(status_q & irq_mask_i);
      end
   end

   assign irq_status_o = status_q;
   assign irq_o        = irq_q;

`else

   logic unused_irq_inputs;

   assign unused_irq_inputs = ^{irq_rise_en_i, irq_fall_en_i, irq_mask_i, irq_clr_i};
   assign irq_status_o      = '0;
   assign irq_o             = 1'b0;

`endif

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank -- directed self-checking bench for gpio_bank (WIDTH=8,
// SYNC_STAGES=2). Inputs change 1 time unit after a rising edge and outputs
// are sampled at that same point, before the next edge. The interrupt
// section depends on whether GPIO_IRQ_EN is defined for the build.
module tb_gpio_bank;
   import gpio_pkg::*;

   logic       clk;
   logic       rst;
   logic [7:0] dir;
   logic       wr_en;
   logic [1:0] wr_op;
   logic [7:0] wr_data;
   logic [7:0] out_val;
   logic [7:0] data_val;
   wire  [7:0] pads;
   logic [7:0] rise_en;
   logic [7:0] fall_en;
   logic [7:0] mask;
   logic [7:0] clr;
   logic [7:0] status;
   logic       irq;

   logic [7:0] ext_en;
   logic [7:0] ext_val;

   int checks;
   int errors;

   for (genvar i = 0; i < 8; i++) begin : g_ext
      assign pads[i] = ext_en[i] ? ext_val[i] : 1'bz;
   end

   gpio_bank #(
      .WIDTH       (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .dir_i         (dir),
      .wr_en_i       (wr_en),
      .wr_op_i       (wr_op),
      .wr_data_i     (wr_data),
      .out_o         (out_val),
      .data_o        (data_val),
      .inout_io      (pads),
      .irq_rise_en_i (rise_en),
      .irq_fall_en_i (fall_en),
      .irq_mask_i    (mask),
      .irq_clr_i     (clr),
      .irq_status_o  (status),
      .irq_o         (irq)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Strobe one output-register write for a single edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data);
      wr_en   = 1'b1;
      wr_op   = op;
      wr_data = data;
      tick(1);
      wr_en   = 1'b0;
   endtask

   // One comparison point.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      dir     = 8'h00;
      wr_en   = 1'b0;
      wr_op   = OP_WRITE;
      wr_data = 8'h00;
      rise_en = 8'h00;
      fall_en = 8'h00;
      mask    = 8'h00;
      clr     = 8'h00;
      ext_en  = 8'h00;
      ext_val = 8'h00;

      // Reset, with a write strobe that reset must override.
      wr_en   = 1'b1;
      wr_data = 8'hFF;
      tick(2);
      wr_en = 1'b0;
      checkOutput("reset_out", 32'(out_val), 32'h00);
      checkOutput("reset_data", 32'(data_val), 32'h00);
      checkOutput("reset_status", 32'(status), 32'h00);
      checkOutput("reset_irq", 32'(irq), 32'h0);
      rst = 1'b0;

      // Output register operations with all pins as outputs.
      dir = 8'hFF;
      applyStimulus(OP_WRITE, 8'hA5);
      checkOutput("write_a5", 32'(out_val), 32'hA5);
      applyStimulus(OP_SET, 8'h0A);
      checkOutput("set_0a", 32'(out_val), 32'hAF);
      checkOutput("pads_driven_af", 32'(pads), 32'hAF);
      tick(2);
      checkOutput("hold_no_wr", 32'(out_val), 32'hAF);
      checkOutput("readback_af", 32'(data_val), 32'hAF);
      applyStimulus(OP_CLEAR, 8'h0F);
      checkOutput("clear_0f", 32'(out_val), 32'hA0);
      applyStimulus(OP_TOGGLE, 8'hFF);
      checkOutput("toggle_ff", 32'(out_val), 32'h5F);
      tick(2);
      checkOutput("readback_5f", 32'(data_val), 32'h5F);

      // Inputs: release the pads, then drive them externally.
      dir = 8'h00;
      tick(1);
      ext_en  = 8'hFF;
      ext_val = 8'h3C;
      tick(1);
      checkOutput("input_lat1", 32'(data_val), 32'h5F);
      tick(1);
      checkOutput("input_lat2", 32'(data_val), 32'h3C);
      checkOutput("input_out_kept", 32'(out_val), 32'h5F);
      checkOutput("input_pads", 32'(pads), 32'h3C);

`ifdef GPIO_IRQ_EN
      // Pads high through reset with every edge enabled: warm-up must hide
      // the apparent 0->1 transition out of reset.
      ext_val = 8'hFF;
      rise_en = 8'hFF;
      fall_en = 8'hFF;
      mask    = 8'h00;
      rst     = 1'b1;
      tick(2);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick(1);
         checkOutput("warmup_status", 32'(status), 32'h00);
      end
      checkOutput("warmup_irq", 32'(irq), 32'h0);

      // Rising edge on pin0 with only that edge enabled.
      rise_en = 8'h01;
      fall_en = 8'h00;
      mask    = 8'h01;
      ext_val = 8'hFE;
      tick(4);
      checkOutput("fall_ignored_pre", 32'(status), 32'h00);
      ext_val = 8'hFF;
      tick(2);
      checkOutput("rise_cyc2", 32'(status), 32'h00);
      tick(1);
      checkOutput("rise_cyc3", 32'(status), 32'h01);
      checkOutput("rise_irq_cyc3", 32'(irq), 32'h0);
      tick(1);
      checkOutput("rise_irq_cyc4", 32'(irq), 32'h1);
      ext_val = 8'hFE;
      tick(4);
      checkOutput("fall_no_change", 32'(status), 32'h01);
      checkOutput("fall_irq_kept", 32'(irq), 32'h1);

      // Clear coincident with a new rise detect: set wins.
      ext_val = 8'hFF;
      tick(2);
      clr = 8'h01;
      tick(1);
      clr = 8'h00;
      checkOutput("set_wins", 32'(status), 32'h01);
      clr = 8'h01;
      tick(1);
      clr = 8'h00;
      checkOutput("clear_alone", 32'(status), 32'h00);
      checkOutput("clear_irq_lag", 32'(irq), 32'h1);
      tick(1);
      checkOutput("clear_irq_low", 32'(irq), 32'h0);

      // Masked pin keeps its status and raises irq once unmasked.
      mask    = 8'h00;
      fall_en = 8'h02;
      ext_val = 8'hFD;
      tick(3);
      checkOutput("masked_status", 32'(status), 32'h02);
      tick(1);
      checkOutput("masked_irq", 32'(irq), 32'h0);
      mask = 8'h02;
      tick(1);
      checkOutput("unmasked_irq", 32'(irq), 32'h1);
      checkOutput("unmasked_status", 32'(status), 32'h02);

      // Output pins never raise status, even with their edge enabled.
      ext_en  = 8'hFB;
      dir     = 8'h04;
      rise_en = 8'h04;
      fall_en = 8'h00;
      clr     = 8'hFF;
      applyStimulus(OP_CLEAR, 8'h04);
      clr = 8'h00;
      tick(3);
      applyStimulus(OP_SET, 8'h04);
      tick(4);
      checkOutput("output_pin_readback", 32'(data_val[2]), 32'h1);
      checkOutput("output_pin_no_status", 32'(status), 32'h00);
`else
      // Without the interrupt option nothing may ever be reported.
      rise_en = 8'hFF;
      fall_en = 8'hFF;
      mask    = 8'hFF;
      for (int k = 0; k < 6; k++) begin
         ext_val = ~ext_val;
         tick(2);
         checkOutput("noirq_status", 32'(status), 32'h00);
         checkOutput("noirq_irq", 32'(irq), 32'h0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
